// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage access controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DW          = 16;
  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for an outstanding bus access.
module mem_timeout_ctr
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access.sv
// Memory-stage controller: one req/ack bus access per load/store,
// bounded wait, pipeline advance/stall generation.
module mem_access
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          IMemRead,
  input  logic          IMemWrite,
  input  logic [DW-1:0] IALUResult,
  input  logic [DW-1:0] IStoreData,
  output logic          OAdvance,
  output logic          OStall,
  output logic [DW-1:0] OLoadData,
  output logic          OBusErr,
  output logic          OMisalign,
  output logic          MemReq,
  output logic          MemWe,
  output logic [DW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData,
  input  logic          MemAck
);

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] ldata_q, ldata_d;
  logic          err_q, err_d;
  logic          mis_q, mis_d;
  logic          odd_q, odd_d;
  logic          ctr_clr, ctr_en, expired;
  logic          op;

  assign op = IMemRead | IMemWrite;

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_ctr (
    .clk_i    (CLK),
    .rst_ni   (Reset),
    .clr_i    (ctr_clr),
    .en_i     (ctr_en),
    .expired_o(expired)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;
    err_d   = err_q;
    mis_d   = mis_q;
    odd_d   = odd_q;
    ctr_clr = 1'b0;
    ctr_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (op) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = IMemWrite;
          addr_d  = {IALUResult[DW-1:1], 1'b0};
          wdata_d = IStoreData;
          odd_d   = IALUResult[0];
          ctr_clr = 1'b1;
        end
      end
      BUSY: begin
        if (MemAck) begin
          state_d = DONE;
          req_d   = 1'b0;
          mis_d   = odd_q;
          if (!we_q) ldata_d = MemRData;
        end else if (expired) begin
          state_d = DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          mis_d   = odd_q;
          if (!we_q) ldata_d = '0;
        end else begin
          ctr_en = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
        mis_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ldata_q <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      odd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      odd_q   <= odd_d;
    end
  end

  // Reset forces advance so the rest of the pipeline is never held.
  assign OAdvance = !Reset
                  || (state_q == DONE)
                  || (state_q == IDLE && !op);
  assign OStall    = ~OAdvance;
  assign OLoadData = ldata_q;
  assign OBusErr   = err_q;
  assign OMisalign = mis_q;
  assign MemReq    = req_q;
  assign MemWe     = we_q;
  assign MemAddr   = addr_q;
  assign MemWData  = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Randomised transaction-level check of mem_access against a
// per-cycle expectation built from access timing rules.
module tb_mem_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        Reset;
  logic        IMemRead, IMemWrite;
  logic [15:0] IALUResult, IStoreData;
  logic        OAdvance, OStall, OBusErr, OMisalign;
  logic [15:0] OLoadData;
  logic        MemReq, MemWe, MemAck;
  logic [15:0] MemAddr, MemWData, MemRData;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic        chk_en = 1'b0;
  logic        chk_regs = 1'b0;
  logic        exp_adv, exp_req, exp_err, exp_mis;
  logic        m_we;
  logic [15:0] m_addr, m_wdata, m_ldata;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(TO)) dut (
    .CLK       (clk),
    .Reset     (Reset),
    .IMemRead  (IMemRead),
    .IMemWrite (IMemWrite),
    .IALUResult(IALUResult),
    .IStoreData(IStoreData),
    .OAdvance  (OAdvance),
    .OStall    (OStall),
    .OLoadData (OLoadData),
    .OBusErr   (OBusErr),
    .OMisalign (OMisalign),
    .MemReq    (MemReq),
    .MemWe     (MemWe),
    .MemAddr   (MemAddr),
    .MemWData  (MemWData),
    .MemRData  (MemRData),
    .MemAck    (MemAck)
  );

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("adv", 16'(OAdvance), 16'(exp_adv));
      chk("stall", 16'(OStall), 16'(!exp_adv));
      if (chk_regs) begin
        chk("req", 16'(MemReq), 16'(exp_req));
        chk("we", 16'(MemWe), 16'(m_we));
        chk("addr", MemAddr, m_addr);
        chk("wdata", MemWData, m_wdata);
        chk("ldata", OLoadData, m_ldata);
        chk("buserr", 16'(OBusErr), 16'(exp_err));
        chk("misalign", 16'(OMisalign), 16'(exp_mis));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      IMemRead   = 1'b0;
      IMemWrite  = 1'b0;
      IALUResult = 16'($urandom);
      IStoreData = 16'($urandom);
      MemAck     = 1'($urandom);
      MemRData   = 16'($urandom);
      exp_adv = 1'b1; exp_req = 1'b0;
      exp_err = 1'b0; exp_mis = 1'b0;
    end
  endtask

  // op seen in cycle 0; ack in cycle ackc (1..TO) ends the wait,
  // anything else times out after TO bus cycles.
  task automatic run_op(input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d,
                        input int ackc, input logic [15:0] rdat);
    bit tmo;
    int e;
    tmo = !(ackc >= 1 && ackc <= TO);
    e   = tmo ? TO : ackc;
    for (int c = 0; c <= e + 1; c++) begin
      @(posedge clk); #1;
      MemRData = 16'($urandom);
      if (c == 0) begin
        IMemRead = rd; IMemWrite = wr;
        IALUResult = a; IStoreData = d;
        MemAck  = 1'($urandom);
        exp_adv = 1'b0; exp_req = 1'b0;
        exp_err = 1'b0; exp_mis = 1'b0;
      end else if (c <= e) begin
        MemAck = (c == ackc);
        if (c == ackc) MemRData = rdat;
        if (c == 1) begin
          m_addr = {a[15:1], 1'b0}; m_we = wr; m_wdata = d;
        end
        exp_adv = 1'b0; exp_req = 1'b1;
      end else begin
        IMemRead = 1'($urandom); IMemWrite = 1'($urandom);
        IALUResult = 16'($urandom);
        MemAck = 1'($urandom);
        if (!wr) m_ldata = tmo ? 16'h0000 : rdat;
        exp_adv = 1'b1; exp_req = 1'b0;
        exp_err = tmo; exp_mis = a[0];
      end
    end
  endtask

  initial begin
    Reset = 1'b0; IMemRead = 1'b1; IMemWrite = 1'b0;
    IALUResult = 16'h0; IStoreData = 16'h0;
    MemAck = 1'b1; MemRData = 16'h0;
    m_addr = '0; m_we = 1'b0; m_wdata = '0; m_ldata = '0;
    exp_adv = 1'b1; exp_req = 1'b0; exp_err = 1'b0; exp_mis = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1; chk_regs = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b1;
    IMemRead = 1'b0;

    idle(10);

    run_op(1'b1, 1'b0, 16'h0040, 16'h0, 1, 16'hBEEF);
    @(negedge clk);
    chk("lit_rd_data", OLoadData, 16'hBEEF);
    chk("lit_rd_adv", 16'(OAdvance), 16'h1);
    chk("lit_rd_err", 16'(OBusErr), 16'h0);

    run_op(1'b0, 1'b1, 16'h1234, 16'hA5A5, 4, 16'h5555);
    @(negedge clk);
    chk("lit_wr_addr", MemAddr, 16'h1234);
    chk("lit_wr_wdata", MemWData, 16'hA5A5);
    chk("lit_wr_ldata", OLoadData, 16'hBEEF);
    chk("lit_wr_err", 16'(OBusErr), 16'h0);

    run_op(1'b1, 1'b0, 16'h0200, 16'h0, 0, 16'h1111);
    @(negedge clk);
    chk("lit_to_err", 16'(OBusErr), 16'h1);
    chk("lit_to_ldata", OLoadData, 16'h0000);
    idle(1);
    @(negedge clk);
    chk("lit_to_idle_err", 16'(OBusErr), 16'h0);

    run_op(1'b1, 1'b0, 16'h0041, 16'h0, 2, 16'h7777);
    @(negedge clk);
    chk("lit_mis", 16'(OMisalign), 16'h1);
    chk("lit_mis_addr", MemAddr, 16'h0040);

    run_op(1'b1, 1'b1, 16'h0ABC, 16'hC3C3, 2, 16'h9999);
    @(negedge clk);
    chk("lit_both_we", 16'(MemWe), 16'h1);
    chk("lit_both_ldata", OLoadData, 16'h7777);

    // reset while the bus is waiting; later ack must be ignored
    @(posedge clk); #1;
    IMemRead = 1'b1; IMemWrite = 1'b0; IALUResult = 16'h0100;
    MemAck = 1'b0;
    exp_adv = 1'b0; exp_req = 1'b0; exp_err = 1'b0; exp_mis = 1'b0;
    @(posedge clk); #1;
    m_addr = 16'h0100; m_we = 1'b0; m_wdata = IStoreData;
    exp_req = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0; exp_adv = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b1; IMemRead = 1'b0; MemAck = 1'b1; MemRData = 16'hDEAD;
    m_addr = '0; m_we = 1'b0; m_wdata = '0; m_ldata = '0;
    exp_req = 1'b0; exp_adv = 1'b1;
    @(negedge clk);
    chk("lit_rst_req", 16'(MemReq), 16'h0);
    chk("lit_rst_ldata", OLoadData, 16'h0);
    idle(2);

    for (int t = 0; t < 40; t++) begin
      logic rd, wr;
      rd = 1'($urandom); wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      run_op(rd, wr, 16'($urandom), 16'($urandom),
             int'($urandom_range(1, TO + 2)), 16'($urandom));
      idle(int'($urandom_range(0, 2)));
    end
    idle(1);
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage access controller for the 16-bit pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register and runs one data-memory read or write per instruction over a req/ack bus with a bounded wait. It produces the load data and the pipeline-advance enable that gates the MEM/WB register's write enable. While an access is outstanding it stalls the earlier stages.

## Interface
- TIMEOUT, default 15: maximum cycles in BUSY without MemAck before the access is aborted; legal range 1..255.
- CLK  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset (sampled on rising CLK).
- IMemRead  in  1  current EX/MEM instruction is a load.
- IMemWrite  in  1  current EX/MEM instruction is a store.
- IALUResult  in  16  byte address of the access.
- IStoreData  in  16  store data.
- OAdvance  out  1  combinational; 1 = MEM/WB may capture and EX/MEM may advance this cycle.
- OStall  out  1  combinational; equals ~OAdvance, to the IF/ID/EX hazard logic.
- OLoadData  out  16  registered load result, feeds the MEM/WB IStoreMem input.
- OBusErr  out  1  registered; high only in the DONE cycle of a timed-out access.
- OMisalign  out  1  registered; high only in the DONE cycle of an access with IALUResult[0]=1.
- MemReq  out  1  registered bus request.
- MemWe  out  1  registered; 1 = write.
- MemAddr  out  16  registered; {IALUResult[15:1],1'b0}.
- MemWData  out  16  registered store data.
- MemRData  in  16  read data, valid in the MemAck cycle.
- MemAck  in  1  access complete; sampled only in BUSY.

## Operation
- States are IDLE, BUSY and DONE.
- IDLE, no op (IMemRead=IMemWrite=0): OAdvance=1, MemReq=0, and the state stays IDLE.
- IDLE, op present: OAdvance=0. The next edge latches MemAddr, MemWe, MemWData and the misalign flag, sets MemReq=1, clears the timeout counter and moves to BUSY.
- IMemRead and IMemWrite both high is treated as a write. OLoadData is unchanged in that case.
- BUSY: OAdvance=0. MemReq, MemWe, MemAddr and MemWData are held stable. Each cycle without an ack increments the counter.
  - MemAck=1: capture MemRData into OLoadData (reads only) and go to DONE with MemReq=0.
  - Counter reaches TIMEOUT-1 with MemAck=0: go to DONE with MemReq=0 and OBusErr=1. A timed-out read sets OLoadData=0x0000; a timed-out write leaves it unchanged.
  - If MemAck arrives on the timeout cycle, the ack wins and OBusErr stays 0.
- DONE: OAdvance=1 for exactly one cycle, then unconditionally return to IDLE. OBusErr and OMisalign clear on leaving DONE.
- MemAck outside BUSY is ignored.
- OLoadData holds its value until the next completed read.

## Timing
- Reset (Reset=0 at an edge) sets: state IDLE, counter 0, MemReq=0, MemWe=0, MemAddr=0, MemWData=0, OLoadData=0, OBusErr=0, OMisalign=0.
- While Reset=0, OAdvance=1 and OStall=0.
- Memory op detected in cycle 0:
  - MemReq is high from cycle 1.
  - An ack sampled in cycle n (n≥1) puts DONE in cycle n+1, with OAdvance=1 and OLoadData valid.
  - A zero-wait memory therefore costs 2 stall cycles.
- Timeout: MemReq is high for cycles 1..TIMEOUT, and DONE falls in cycle TIMEOUT+1.
- Reset during BUSY drops MemReq at that edge. An ack arriving after reset is ignored.
- The bus is never re-requested for the same instruction, because DONE always advances the pipeline.

## Structure
- Shared package `mem_pkg` holds:
  - the state enum (IDLE, BUSY, DONE);
  - the 16-bit data/address width constant;
  - the default TIMEOUT constant.
- The counter width is derived from TIMEOUT in the module.
- One sub-module, `mem_timeout_ctr`, is natural: clear, enable, and an expired flag at TIMEOUT-1.

## Test plan
- No-op stream for 10 cycles -> OAdvance=1 every cycle, MemReq never asserted.
- Read at 0x0040 with MemAck in cycle 1 and MemRData=0xBEEF -> MemReq high in cycle 1 only, OAdvance=1 in cycle 2, OLoadData=0xBEEF, OBusErr=0.
- Write of 0xA5A5 to 0x1234 with ack in cycle 4 -> MemAddr=0x1234, MemWe=1 and MemWData=0xA5A5 stable for cycles 1-4; OAdvance=1 in cycle 5; OLoadData unchanged.
- TIMEOUT=4, read with no ack -> MemReq high in cycles 1-4; cycle 5 has OBusErr=1, OLoadData=0x0000, OAdvance=1; cycle 6 is IDLE.
- Read at 0x0041 with ack in cycle 2 -> MemAddr=0x0040, OMisalign=1 only in cycle 3.
- Reset asserted in cycle 2 of BUSY, then ack in cycle 3 -> MemReq=0 from the reset edge, all outputs at reset values, ack ignored, state IDLE.
